// File: rtl/fft_reorder_pp.sv
// Ping-pong output reorder buffer: takes bit-reversed FFT frames and emits them in natural order.
// Optional FFT_REORDER_DROP_CNT_EN adds a saturating 16-bit count of dropped frames on drop_cnt.
module fft_reorder_pp #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_start,
    input  logic         in_valid,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_sof,
    output logic         out_eof,
    output logic         frame_drop
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    output logic [15:0]  drop_cnt
`endif
);

    localparam int DEPTH = 1 << N;
    localparam logic [N-1:0] CNT_ZERO = '0;
    localparam logic [N-1:0] CNT_ONE  = N'(1'b1);
    localparam logic [N-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_SKIP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } r_state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = a[N-1-i];
        end
        return r;
    endfunction

    // {bank, addr} indexes the two banks back to back
    logic [2*W-1:0] mem_r [0:2*DEPTH-1];

    w_state_t       w_state_r, w_state_s;
    logic [N-1:0]   wr_cnt_r, wr_cnt_s;
    logic           wr_bank_r, wr_bank_s;
    logic           we_s;
    logic [N-1:0]   waddr_s;
    logic           drop_s;
    logic           set_full_s;
    logic           bank_free_s;

    r_state_t       rd_state_r, rd_state_s;
    logic [N-1:0]   rd_cnt_r, rd_cnt_s;
    logic           rd_bank_r, rd_bank_s;
    logic           rd_hs_s;
    logic           rd_last_hs_s;
    logic           load_s;
    logic           clr_full_s;

    logic [1:0]     full_r, full_s;

    logic           out_valid_r;
    logic [W-1:0]   out_re_r;
    logic [W-1:0]   out_im_r;
    logic           out_sof_r;
    logic           out_eof_r;
    logic           frame_drop_r;

    // Read-side next state: registered output slot advances on each handshake
    always_comb begin
        rd_state_s   = rd_state_r;
        rd_cnt_s     = rd_cnt_r;
        rd_bank_s    = rd_bank_r;
        load_s       = 1'b0;
        clr_full_s   = 1'b0;
        rd_hs_s      = (rd_state_r == R_SEND) && out_ready;
        rd_last_hs_s = rd_hs_s && (rd_cnt_r == CNT_MAX);
        case (rd_state_r)
            R_IDLE: begin
                if (full_r[rd_bank_r]) begin
                    rd_state_s = R_SEND;
                    rd_cnt_s   = CNT_ZERO;
                    load_s     = 1'b1;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_SEND: begin
                if (rd_hs_s) begin
                    if (rd_cnt_r == CNT_MAX) begin
                        clr_full_s = 1'b1;
                        rd_bank_s  = ~rd_bank_r;
                        rd_cnt_s   = CNT_ZERO;
                        // Chain straight into the other bank so back-to-back frames have no gap
                        if (full_r[~rd_bank_r]) begin
                            load_s     = 1'b1;
                            rd_state_s = R_SEND;
                        end else begin
                            rd_state_s = R_IDLE;
                        end
                    end else begin
                        rd_cnt_s = rd_cnt_r + CNT_ONE;
                        load_s   = 1'b1;
                    end
                end else begin
                    rd_state_s = R_SEND;
                end
            end
            default: begin
                rd_state_s = R_IDLE;
            end
        endcase
    end

    // Write-side next state: a start always restarts the frame in the current write bank
    always_comb begin
        w_state_s   = w_state_r;
        wr_cnt_s    = wr_cnt_r;
        wr_bank_s   = wr_bank_r;
        we_s        = 1'b0;
        waddr_s     = CNT_ZERO;
        drop_s      = 1'b0;
        set_full_s  = 1'b0;
        bank_free_s = !full_r[wr_bank_r] || (rd_last_hs_s && (rd_bank_r == wr_bank_r));
        if (in_valid && in_start) begin
            wr_cnt_s = CNT_ONE;
            if (bank_free_s) begin
                we_s      = 1'b1;
                waddr_s   = CNT_ZERO;
                w_state_s = W_FILL;
            end else begin
                drop_s    = 1'b1;
                w_state_s = W_SKIP;
            end
        end else if (in_valid) begin
            case (w_state_r)
                W_FILL: begin
                    we_s     = 1'b1;
                    waddr_s  = bitrev(wr_cnt_r);
                    wr_cnt_s = wr_cnt_r + CNT_ONE;
                    if (wr_cnt_r == CNT_MAX) begin
                        set_full_s = 1'b1;
                        wr_bank_s  = ~wr_bank_r;
                        w_state_s  = W_IDLE;
                    end else begin
                        w_state_s = W_FILL;
                    end
                end
                W_SKIP: begin
                    wr_cnt_s = wr_cnt_r + CNT_ONE;
                    if (wr_cnt_r == CNT_MAX) begin
                        w_state_s = W_IDLE;
                    end else begin
                        w_state_s = W_SKIP;
                    end
                end
                W_IDLE: begin
                    w_state_s = W_IDLE;
                end
                default: begin
                    w_state_s = W_IDLE;
                end
            endcase
        end else begin
            w_state_s = w_state_r;
        end
    end

    // Full flags: read side releases a bank, write side claims it on the final sample
    always_comb begin
        full_s = full_r;
        if (clr_full_s) begin
            full_s[rd_bank_r] = 1'b0;
        end else begin
            full_s[rd_bank_r] = full_r[rd_bank_r];
        end
        if (set_full_s) begin
            full_s[wr_bank_r] = 1'b1;
        end else begin
            full_s[wr_bank_r] = full_s[wr_bank_r];
        end
    end

    // Control state registers for both FSMs, counters, banks and full flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_r  <= W_IDLE;
            wr_cnt_r   <= CNT_ZERO;
            wr_bank_r  <= 1'b0;
            rd_state_r <= R_IDLE;
            rd_cnt_r   <= CNT_ZERO;
            rd_bank_r  <= 1'b0;
            full_r     <= 2'b00;
        end else begin
            w_state_r  <= w_state_s;
            wr_cnt_r   <= wr_cnt_s;
            wr_bank_r  <= wr_bank_s;
            rd_state_r <= rd_state_s;
            rd_cnt_r   <= rd_cnt_s;
            rd_bank_r  <= rd_bank_s;
            full_r     <= full_s;
        end
    end

    // Sample storage; contents are never observed before a bank is marked full
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[{wr_bank_r, waddr_s}] <= {in_re, in_im};
        end
    end

    // Registered output stage; data and frame markers hold while the sink stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_re_r     <= '0;
            out_im_r     <= '0;
            out_sof_r    <= 1'b0;
            out_eof_r    <= 1'b0;
            frame_drop_r <= 1'b0;
        end else begin
            out_valid_r  <= (rd_state_s == R_SEND);
            out_sof_r    <= (rd_state_s == R_SEND) && (rd_cnt_s == CNT_ZERO);
            out_eof_r    <= (rd_state_s == R_SEND) && (rd_cnt_s == CNT_MAX);
            frame_drop_r <= drop_s;
            if (load_s) begin
                {out_re_r, out_im_r} <= mem_r[{rd_bank_s, rd_cnt_s}];
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_re     = out_re_r;
    assign out_im     = out_im_r;
    assign out_sof    = out_sof_r;
    assign out_eof    = out_eof_r;
    assign frame_drop = frame_drop_r;

`ifdef FFT_REORDER_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of discarded frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    // Drop counter not built; frame_drop alone reports discarded frames
`endif

endmodule

// File: tb/tb_fft_reorder_pp.sv
// Directed scoreboard bench for fft_reorder_pp (N=3, W=16).
module tb_fft_reorder_pp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = 16'd0;
    logic [15:0] in_im = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_sof;
    logic        out_eof;
    logic        frame_drop;
`ifdef FFT_REORDER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int drop_seen = 0;
    int run_cur = 0;
    int last_run = 0;

    fft_reorder_pp #(.N(3), .W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_start   (in_start),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .frame_drop (frame_drop)
`ifdef FFT_REORDER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Natural-order position j holds arrival index br(j) for an 8-point frame
    function automatic int br(input int j);
        case (j)
            0: return 0;
            1: return 4;
            2: return 2;
            3: return 6;
            4: return 1;
            5: return 5;
            6: return 3;
            7: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (out_valid === 1'b1) begin
            run_cur++;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_out: observed re=%0d, expected no output", out_re);
            end
            if (sb.size() > 0) begin
                e = sb[0];
                chk("out_sample", 64'({out_re, out_im, out_sof, out_eof}),
                    64'({e.re, e.im, e.sof, e.eof}));
                if (out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end else begin
            if (run_cur > 0) begin
                last_run = run_cur;
            end
            run_cur = 0;
        end
        if (frame_drop === 1'b1) begin
            drop_seen++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input int base, input bit push);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            tick();
            in_start = (k == 0);
            in_valid = 1'b1;
            in_re    = 16'(base + k);
            in_im    = 16'(-(base + k));
        end
        if (push) begin
            for (int j = 0; j < 8; j++) begin
                e.re  = 16'(base + br(j));
                e.im  = 16'(-(base + br(j)));
                e.sof = (j == 0);
                e.eof = (j == 7);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        tick();
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while (((sb.size() != 0) || (out_valid === 1'b1)) && (n < 300)) begin
            if (toggle) begin
                out_ready = ~out_ready;
            end
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 300), 64'd1);
        tick();
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_outputs", 64'({out_valid, out_sof, out_eof, frame_drop, out_re, out_im}), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Single frame, ready high, check first-output latency
        out_ready = 1'b1;
        send_frame(0, 1'b1);
        idle();
        chk("t1_valid_after_last_capture", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_next_cycle", 64'(out_valid), 64'd1);
        drain(1'b0);
        chk("t1_run_len", 64'(last_run), 64'd8);

        // Same frame with ready toggling
        send_frame(0, 1'b1);
        idle();
        drain(1'b1);
        out_ready = 1'b1;
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Two back-to-back frames, no bubble, no drop
        send_frame(0, 1'b1);
        send_frame(8, 1'b1);
        idle();
        drain(1'b0);
        chk("t3_run_len", 64'(last_run), 64'd16);
        chk("t3_no_drop", 64'(drop_seen), 64'd0);

        // Three frames while stalled: third one is dropped
        out_ready = 1'b0;
        send_frame(200, 1'b1);
        send_frame(208, 1'b1);
        tick();
        in_start = 1'b1;
        in_valid = 1'b1;
        in_re    = 16'd216;
        in_im    = 16'(-216);
        tick();
        chk("t4_drop_pulse", 64'(frame_drop), 64'd1);
        in_start = 1'b0;
        in_re    = 16'd217;
        in_im    = 16'(-217);
        for (int k = 2; k < 8; k++) begin
            tick();
            in_re = 16'(216 + k);
            in_im = 16'(-(216 + k));
        end
        idle();
        tick();
        chk("t4_drop_once", 64'(drop_seen), 64'd1);
`ifdef FFT_REORDER_DROP_CNT_EN
        chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        chk("t4_stalled_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain(1'b0);

        // Restart mid-frame: partial frame must never appear
        for (int k = 0; k < 5; k++) begin
            tick();
            in_start = (k == 0);
            in_valid = 1'b1;
            in_re    = 16'(50 + k);
            in_im    = 16'(-(50 + k));
        end
        send_frame(100, 1'b1);
        idle();
        drain(1'b0);
        chk("t5_run_len", 64'(last_run), 64'd8);

        // Asynchronous reset mid-read
        out_ready = 1'b0;
        send_frame(300, 1'b1);
        idle();
        repeat (3) tick();
        chk("t6_valid_before_reset", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_async_clear", 64'({out_valid, out_sof, out_eof, out_re, out_im}), 64'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("t6_no_output_after_reset", 64'(out_valid), 64'd0);
        send_frame(400, 1'b1);
        idle();
        drain(1'b0);
        chk("t6_run_len", 64'(last_run), 64'd8);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
